// File: rtl/ccff_prog_ctrl_pkg.sv
// Shared definitions for the configuration-chain programming controller.
//   state_t        : controller state encoding (IDLE, LOAD, STALL, DONE)
//   DEF_CHAIN_LEN  : default number of flip-flops in the target ccff chain
//   DEF_DATA_W     : default width of host configuration / readback words
package ccff_prog_ctrl_pkg;

  localparam int DEF_CHAIN_LEN = 48;
  localparam int DEF_DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STALL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ccff_prog_sipo.sv
// Readback capture: collects the bits leaving the chain tail MSB-first into a
// DATA_W-bit word and presents it for one cycle when the word is full or the
// final chain bit has been captured (partial word left-aligned, zero filled).
// Ports:
//   prog_clk, pReset : clock and asynchronous active-high reset
//   clear            : drop any partially captured word
//   cap_en           : capture cap_bit on this edge
//   cap_bit          : serial bit from the chain tail
//   cap_last         : this capture is the final bit of the chain
//   rb_data          : captured word (held until the next word)
//   rb_valid         : one-cycle strobe for rb_data
module ccff_prog_sipo
  import ccff_prog_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clear,
  input  logic              cap_en,
  input  logic              cap_bit,
  input  logic              cap_last,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] word_reg;
  logic [DATA_W-1:0] word_next;
  logic [CW-1:0]     cnt_reg;
  logic              flush;

  // Each capture lands directly in its final left-aligned position, so a
  // partial word needs no extra alignment shift when flushed.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign word_next[gi] = (cap_en && (cnt_reg == CW'(DATA_W - 1 - gi))) ? cap_bit
                                                                             : word_reg[gi];
    end
  endgenerate

  assign flush = cap_en && (cap_last || (cnt_reg == CW'(DATA_W - 1)));

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      word_reg <= '0;
      cnt_reg  <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clear) begin
        word_reg <= '0;
        cnt_reg  <= '0;
      end else if (flush) begin
        rb_data  <= word_next;
        rb_valid <= 1'b1;
        word_reg <= '0;
        cnt_reg  <= '0;
      end else if (cap_en) begin
        word_reg <= word_next;
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_prog_ctrl.sv
// Programs one full configuration-flip-flop chain from host words, shifting
// each word MSB-first into the chain head while reading the previous chain
// contents back from the tail.
// Ports:
//   prog_clk, pReset     : clock and asynchronous active-high reset
//   start, abort         : begin a programming pass / terminate immediately
//   cfg_data/valid/ready : host configuration word handshake
//   ccff_head            : serial bit into the chain head
//   ccff_shift_en        : chain clock-enable
//   ccff_tail            : serial bit from the chain tail
//   rb_data, rb_valid    : readback words of the previous chain contents
//   busy, done           : pass in progress / one-cycle completion pulse
module ccff_prog_ctrl
  import ccff_prog_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BV_W  = $clog2(DATA_W + 1);

  state_t            state_reg;
  logic [DATA_W-1:0] shbuf_reg;
  logic [BV_W-1:0]   bv_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              in_prog;
  logic              shift;
  logic              accept;
  logic              last_bit;
  int                remaining;
  logic [BV_W-1:0]   load_bits;

  assign in_prog = (state_reg == ST_LOAD) || (state_reg == ST_STALL);
  assign shift   = (state_reg == ST_LOAD) && (bv_reg != '0) && !abort;

  // Chain bits not yet committed to the buffer once this cycle's shift is
  // done. It sizes the next load, which truncates the final word, and it
  // closes cfg_ready once the last word is in, so no surplus word is taken.
  assign remaining = CHAIN_LEN - int'(cnt_reg) - int'(bv_reg);
  assign load_bits = (remaining >= DATA_W) ? BV_W'(DATA_W) : BV_W'(remaining);

  // Refill when empty, or when the single remaining bit leaves this cycle.
  assign cfg_ready = in_prog && !abort && (remaining > 0) &&
                     ((bv_reg == '0) || ((bv_reg == BV_W'(1)) && shift));
  assign accept    = cfg_valid && cfg_ready;
  assign last_bit  = shift && (cnt_reg == CNT_W'(CHAIN_LEN - 1));

  assign ccff_shift_en = shift;
  assign ccff_head     = shift & shbuf_reg[DATA_W-1];
  assign busy          = in_prog;
  assign done          = (state_reg == ST_DONE);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_reg <= ST_IDLE;
      shbuf_reg <= '0;
      bv_reg    <= '0;
      cnt_reg   <= '0;
    end else if (abort) begin
      state_reg <= ST_IDLE;
      shbuf_reg <= '0;
      bv_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_LOAD;
            shbuf_reg <= '0;
            bv_reg    <= '0;
            cnt_reg   <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            shbuf_reg <= cfg_data;
            bv_reg    <= load_bits;
          end else if (shift) begin
            shbuf_reg <= shbuf_reg << 1;
            bv_reg    <= bv_reg - 1'b1;
          end
          if (shift) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (last_bit) begin
            state_reg <= ST_DONE;
          end else if ((bv_reg == '0) && !accept) begin
            state_reg <= ST_STALL;
          end
        end
        ST_STALL: begin
          if (accept) begin
            shbuf_reg <= cfg_data;
            bv_reg    <= load_bits;
            state_reg <= ST_LOAD;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  ccff_prog_sipo #(
    .DATA_W(DATA_W)
  ) u_sipo (
    .prog_clk(prog_clk),
    .pReset  (pReset),
    .clear   (abort),
    .cap_en  (shift),
    .cap_bit (ccff_tail),
    .cap_last(last_bit),
    .rb_data (rb_data),
    .rb_valid(rb_valid)
  );

endmodule

// File: tb/tb_ccff_prog_ctrl.sv
// Bench for ccff_prog_ctrl: a 48-bit and a 20-bit instance, each driving a
// behavioural chain model; expectations come from the host words and from
// snapshots of the chain model taken at the start of each pass.
module tb_ccff_prog_ctrl;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // 48-bit instance signals
  logic       start48 = 0, abort48 = 0, cfg_valid48 = 0;
  logic [7:0] cfg_data48 = '0;
  logic       cfg_ready48, head48, sen48, rbv48, busy48, done48;
  logic [7:0] rb48;
  logic [47:0] chain48, seed48;
  logic        tail48;
  // 20-bit instance signals
  logic       start20 = 0, abort20 = 0, cfg_valid20 = 0;
  logic [7:0] cfg_data20 = '0;
  logic       cfg_ready20, head20, sen20, rbv20, busy20, done20;
  logic [7:0] rb20;
  logic [19:0] chain20, seed20;
  logic        tail20;
  logic        seed_en = 0;

  ccff_prog_ctrl #(.CHAIN_LEN(48), .DATA_W(8)) u48 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start48), .abort(abort48),
    .cfg_data(cfg_data48), .cfg_valid(cfg_valid48), .cfg_ready(cfg_ready48),
    .ccff_head(head48), .ccff_shift_en(sen48), .ccff_tail(tail48),
    .rb_data(rb48), .rb_valid(rbv48), .busy(busy48), .done(done48));

  ccff_prog_ctrl #(.CHAIN_LEN(20), .DATA_W(8)) u20 (
    .prog_clk(prog_clk), .pReset(pReset), .start(start20), .abort(abort20),
    .cfg_data(cfg_data20), .cfg_valid(cfg_valid20), .cfg_ready(cfg_ready20),
    .ccff_head(head20), .ccff_shift_en(sen20), .ccff_tail(tail20),
    .rb_data(rb20), .rb_valid(rbv20), .busy(busy20), .done(done20));

  // Behavioural chains: head enters bit 0, tail leaves from the top bit.
  assign tail48 = chain48[47];
  assign tail20 = chain20[19];
  always @(posedge prog_clk) begin
    if (seed_en) begin
      chain48 <= seed48;
      chain20 <= seed20;
    end else begin
      if (sen48) chain48 <= {chain48[46:0], head48};
      if (sen20) chain20 <= {chain20[18:0], head20};
    end
  end

  // Observation logs
  int head_q48[$], cyc_q48[$], rb_q48[$], done_q48[$];
  int head_q20[$], cyc_q20[$], rb_q20[$], done_q20[$];
  always @(negedge prog_clk) begin
    if (sen48) begin head_q48.push_back(int'(head48)); cyc_q48.push_back(cyc); end
    if (rbv48) rb_q48.push_back(int'(rb48));
    if (done48) done_q48.push_back(cyc);
    if (sen20) begin head_q20.push_back(int'(head20)); cyc_q20.push_back(cyc); end
    if (rbv20) rb_q20.push_back(int'(rb20));
    if (done20) done_q20.push_back(cyc);
  end

  int total = 0;
  int bad   = 0;
  int h0, c0, r0, d0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge prog_clk); #1; end
  endtask

  task automatic mark(input int n);
    if (n == 48) begin
      h0 = head_q48.size(); c0 = cyc_q48.size(); r0 = rb_q48.size(); d0 = done_q48.size();
    end else begin
      h0 = head_q20.size(); c0 = cyc_q20.size(); r0 = rb_q20.size(); d0 = done_q20.size();
    end
  endtask

  task automatic pulse_start48();
    start48 = 1'b1; step(1); start48 = 1'b0;
  endtask

  // Offer words to the 48-bit instance. Optionally withholds cfg_valid for
  // hold_n ready cycles before word hold_at, inserts random gaps, or returns
  // early once stop_at bits have shifted in this pass.
  task automatic feed48(input int w[$], input int hold_at, input int hold_n,
                        input bit rnd, input int stop_at);
    int idx = 0, held = 0, guard = 0;
    bit want, stopped = 0;
    while (idx < w.size() && guard < 1000 && !stopped) begin
      guard++;
      want = 1'b1;
      if (idx == hold_at && held < hold_n) want = 1'b0;
      if (rnd && $urandom_range(0, 3) == 0) want = 1'b0;
      cfg_valid48 = want;
      cfg_data48  = want ? 8'(w[idx]) : 8'($urandom);
      @(negedge prog_clk); #1;
      if (idx == hold_at && !want && cfg_ready48) begin
        held++;
        if (held == hold_n) begin
          chk("stall_shift_en", 64'(sen48), 64'd0);
          chk("stall_busy", 64'(busy48), 64'd1);
          chk("stall_count", 64'(head_q48.size() - h0), 64'(8 * hold_at));
        end
      end
      if (want && cfg_ready48) idx++;
      if (stop_at > 0 && (head_q48.size() - h0) >= stop_at) stopped = 1'b1;
      @(posedge prog_clk); #1;
    end
    cfg_valid48 = 1'b0;
    chk("feed48_bound", 64'(guard < 1000), 64'd1);
  endtask

  task automatic wait_done48();
    int g = 0;
    while (done_q48.size() == d0 && g < 400) begin step(1); g++; end
    step(3);
  endtask

  // Runs one 20-bit pass holding cfg_valid high throughout; returns accepts.
  task automatic run20(input int w[$], output int acc);
    int idx = 0, g = 0;
    acc = 0;
    start20 = 1'b1; step(1); start20 = 1'b0;
    while (done_q20.size() == d0 && g < 400) begin
      g++;
      cfg_valid20 = 1'b1;
      cfg_data20  = (idx < w.size()) ? 8'(w[idx]) : 8'h5A;
      @(negedge prog_clk); #1;
      if (cfg_ready20) begin acc++; idx++; end
      @(posedge prog_clk); #1;
    end
    cfg_valid20 = 1'b0;
    step(3);
  endtask

  task automatic check_pass(input string tag, input int n, input int w[$],
                            input logic [63:0] snap, input bit consec);
    int hq[$], cq[$], rq[$], dq[$];
    logic [63:0] got_h, exp_h, exp_rb, o;
    int nw, wv, bi;
    if (n == 48) begin
      hq = head_q48[h0:$]; cq = cyc_q48[c0:$]; rq = rb_q48[r0:$]; dq = done_q48[d0:$];
    end else begin
      hq = head_q20[h0:$]; cq = cyc_q20[c0:$]; rq = rb_q20[r0:$]; dq = done_q20[d0:$];
    end
    nw = (n + 7) / 8;
    got_h = '0;
    exp_h = '0;
    for (int j = 0; j < n; j++) begin
      wv = w[j / 8];
      exp_h[j] = wv[7 - (j % 8)];
      if (j < hq.size()) got_h[j] = hq[j][0];
    end
    chk({tag, "_shifts"}, 64'(hq.size()), 64'(n));
    chk({tag, "_heads"}, got_h, exp_h);
    if (consec && cq.size() == n) chk({tag, "_consecutive"}, 64'(cq[n-1] - cq[0]), 64'(n - 1));
    chk({tag, "_done_count"}, 64'(dq.size()), 64'd1);
    if (dq.size() > 0 && cq.size() > 0)
      chk({tag, "_done_latency"}, 64'(dq[0] - cq[cq.size()-1]), 64'd1);
    chk({tag, "_rb_count"}, 64'(rq.size()), 64'(nw));
    for (int k = 0; k < nw; k++) begin
      exp_rb = '0;
      for (int i = 0; i < 8; i++) begin
        bi = 8 * k + i;
        if (bi < n) exp_rb[7 - i] = snap[n - 1 - bi];
      end
      o = (k < rq.size()) ? 64'(rq[k]) : '1;
      chk($sformatf("%s_rb%0d", tag, k), o, exp_rb);
    end
    $display("%s: shifts=%0d done=%0d rb_words=%0d", tag, hq.size(), dq.size(), rq.size());
  endtask

  initial begin
    int w[$], w20[$];
    logic [63:0] snap;
    int acc;

    // ---- reset ----
    seed48 = 48'({$urandom, $urandom});
    seed20 = 20'($urandom);
    #1 pReset = 1'b1;
    #1;
    chk("rst_ctrl48", 64'({cfg_ready48, head48, sen48, rbv48, busy48, done48}), 64'd0);
    chk("rst_rb48", 64'(rb48), 64'd0);
    chk("rst_ctrl20", 64'({cfg_ready20, head20, sen20, rbv20, busy20, done20, rb20}), 64'd0);
    seed_en = 1'b1;
    @(posedge prog_clk); #1;
    seed_en = 1'b0;
    step(1);
    pReset = 1'b0;
    step(1);

    // ---- pass 1: A5..AA back-to-back ----
    w = {};
    for (int k = 0; k < 6; k++) w.push_back(8'hA5 + k);
    mark(48); snap = 64'(chain48);
    pulse_start48();
    feed48(w, -1, 0, 1'b0, 0);
    wait_done48();
    check_pass("p1_a5", 48, w, snap, 1'b1);

    // ---- pass 2: same words, 3-cycle stall after word 2 ----
    mark(48); snap = 64'(chain48);
    pulse_start48();
    feed48(w, 2, 3, 1'b0, 0);
    wait_done48();
    check_pass("p2_stall", 48, w, snap, 1'b0);
    for (int k = 0; k < 6; k++)
      if (r0 + k < rb_q48.size()) chk($sformatf("p2_readback%0d", k), 64'(rb_q48[r0+k]), 64'(8'hA5 + k));
    if (c0 + 16 < cyc_q48.size())
      chk("p2_stall_gap", 64'(cyc_q48[c0+16] - cyc_q48[c0+15]), 64'd4);

    // ---- pass 3: random words, random gaps, start held (ignored while busy) ----
    w = {};
    for (int k = 0; k < 6; k++) w.push_back(int'($urandom_range(0, 255)));
    mark(48); snap = 64'(chain48);
    start48 = 1'b1;
    feed48(w, -1, 0, 1'b1, 0);
    start48 = 1'b0;
    wait_done48();
    check_pass("p3_random", 48, w, snap, 1'b0);

    // ---- pass 4: abort after bit 13 ----
    w = {};
    for (int k = 0; k < 6; k++) w.push_back(int'($urandom_range(0, 255)));
    mark(48);
    pulse_start48();
    feed48(w, -1, 0, 1'b0, 13);
    abort48 = 1'b1;
    #1;
    chk("abort_shift_en", 64'(sen48), 64'd0);
    @(negedge prog_clk); #1;
    chk("abort_ready", 64'(cfg_ready48), 64'd0);
    step(1);
    abort48 = 1'b0;
    chk("abort_idle", 64'({busy48, done48}), 64'd0);
    step(12);
    chk("abort_shifts", 64'(head_q48.size() - h0), 64'd13);
    chk("abort_no_done", 64'(done_q48.size() - d0), 64'd0);
    chk("abort_rb_count", 64'(rb_q48.size() - r0), 64'd1);
    $display("p4_abort: shifts=%0d rb_words=%0d", head_q48.size() - h0, rb_q48.size() - r0);

    // ---- pass 5: full program after abort starts from count 0 ----
    mark(48); snap = 64'(chain48);
    pulse_start48();
    feed48(w, -1, 0, 1'b0, 0);
    wait_done48();
    check_pass("p5_after_abort", 48, w, snap, 1'b1);

    // ---- start and abort together in IDLE ----
    mark(48);
    start48 = 1'b1; abort48 = 1'b1;
    step(1);
    start48 = 1'b0; abort48 = 1'b0;
    chk("start_abort_busy", 64'(busy48), 64'd0);
    step(3);
    chk("start_abort_shifts", 64'(head_q48.size() - h0), 64'd0);
    $display("p6_start_abort: busy=%0d", busy48);

    // ---- pass 7: reset mid-LOAD, then a fresh program ----
    mark(48);
    pulse_start48();
    feed48(w, -1, 0, 1'b0, 20);
    chk("pre_reset_busy", 64'(busy48), 64'd1);
    #2 pReset = 1'b1;
    #1;
    chk("mid_reset_ctrl", 64'({cfg_ready48, head48, sen48, rbv48, busy48, done48}), 64'd0);
    chk("mid_reset_rb", 64'(rb48), 64'd0);
    step(2);
    pReset = 1'b0;
    step(1);
    w = {};
    for (int k = 0; k < 6; k++) w.push_back(int'($urandom_range(0, 255)));
    mark(48); snap = 64'(chain48);
    pulse_start48();
    feed48(w, -1, 0, 1'b0, 0);
    wait_done48();
    check_pass("p7_after_reset", 48, w, snap, 1'b1);

    // ---- 20-bit chain: FF,00,F0 twice ----
    w20 = {8'hFF, 8'h00, 8'hF0};
    mark(20); snap = 64'(chain20);
    run20(w20, acc);
    chk("c20a_accepts", 64'(acc), 64'd3);
    check_pass("c20a", 20, w20, snap, 1'b1);
    mark(20); snap = 64'(chain20);
    run20(w20, acc);
    chk("c20b_accepts", 64'(acc), 64'd3);
    check_pass("c20b", 20, w20, snap, 1'b1);
    if (r0 + 2 < rb_q20.size()) chk("c20b_last_word", 64'(rb_q20[r0+2]), 64'h0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/ccff_prog_ctrl.md
CCFF_PROG_CTRL -- requirements
Module: ccff_prog_ctrl

Interface
REQ-001 Parameter CHAIN_LEN, default 48, number of configuration flip-flops in the target ccff chain (switch block sb_0__1_ total).
REQ-002 Parameter DATA_W, default 8, width of the host configuration word and of the readback word.
REQ-003 prog_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 pReset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin programming one full chain.
REQ-006 abort  input  1  terminate programming immediately.
REQ-007 cfg_data  input  DATA_W  configuration word, MSB shifted first.
REQ-008 cfg_valid  input  1  cfg_data valid.
REQ-009 cfg_ready  output  1  controller accepts cfg_data this cycle.
REQ-010 ccff_head  output  1  serial bit into the chain head.
REQ-011 ccff_shift_en  output  1  chain clock-enable; the chain SHALL advance only on edges where this is 1.
REQ-012 ccff_tail  input  1  serial bit from the chain tail.
REQ-013 rb_data  output  DATA_W  readback word of the previous chain contents.
REQ-014 rb_valid  output  1  rb_data valid for one cycle; no backpressure.
REQ-015 busy  output  1  high in LOAD or STALL.
REQ-016 done  output  1  one-cycle pulse when the last chain bit has shifted.

Function
REQ-017 States SHALL be IDLE, LOAD, STALL, DONE.
REQ-018 IDLE: start=1 -> LOAD on the next edge; start while not IDLE SHALL be ignored.
REQ-019 The controller SHALL hold a DATA_W-bit shift buffer and a bit-valid counter; cfg_ready SHALL be 1 in LOAD/STALL when the buffer is empty or holds exactly one bit that shifts this cycle (zero-bubble refill).
REQ-020 A word SHALL be accepted on an edge with cfg_valid and cfg_ready both 1; cfg_data SHALL be ignored otherwise.
REQ-021 LOAD: when the buffer holds a bit, ccff_shift_en=1 and ccff_head=buffer MSB; the buffer SHALL shift left and the chain bit counter SHALL increment.
REQ-022 LOAD with an empty buffer and no word accepted -> STALL; STALL holds ccff_shift_en=0 and returns to LOAD on the edge that accepts a word.
REQ-023 Word count SHALL be ceil(CHAIN_LEN/DATA_W); in the final word only the top (CHAIN_LEN mod DATA_W) bits are shifted when that remainder is nonzero, and the unused bits are discarded.
REQ-024 After CHAIN_LEN shifts the controller SHALL enter DONE, with cfg_ready=0 from that edge onward; DONE asserts done for one cycle, then IDLE.
REQ-025 On every shift edge ccff_tail SHALL be captured MSB-first into a readback register; rb_valid SHALL pulse the cycle after DATA_W captures and after the final capture; the final partial word is left-aligned with zero fill.
REQ-026 Bit counter width SHALL be clog2(CHAIN_LEN+1); the counter SHALL never exceed CHAIN_LEN.
REQ-027 abort in any state -> IDLE on the next edge; ccff_shift_en SHALL be 0 combinationally while abort=1; no done pulse; the partial readback word SHALL be dropped.
REQ-028 abort and start asserted together in IDLE: abort SHALL win.
REQ-029 ccff_shift_en and ccff_head SHALL be 0 outside LOAD.

Reset
REQ-030 While pReset=1: state=IDLE; cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy and done are 0; rb_data and all counters/buffers are 0.
REQ-031 pReset mid-programming SHALL discard progress; the chain contents are then undefined and a new start is required.

Structure
REQ-032 A shared package SHALL hold the state enum and the default CHAIN_LEN/DATA_W constants.
REQ-033 One sub-module, ccff_prog_sipo, SHALL implement the readback serial-in/parallel-out capture with its count and flush logic.

Verification
REQ-034 CHAIN_LEN=48, DATA_W=8, 6 words 0xA5..0xAA back-to-back -> 48 consecutive shift_en cycles, head = MSB-first bits, done 1 cycle after the 48th shift.
REQ-035 Two full programs with a behavioural 48-bit chain model -> second pass rb_data sequence equals the first pass words 0xA5..0xAA.
REQ-036 cfg_valid withheld 3 cycles after word 2 -> STALL, shift_en=0 for exactly those 3 cycles, counter frozen at 16.
REQ-037 CHAIN_LEN=20, DATA_W=8, words 0xFF,0x00,0xF0 -> 20 shifts, last 4 bits 1111, final rb_data left-aligned with low nibble 0.
REQ-038 abort after bit 13 -> shift_en low the same cycle, IDLE next edge, no done and no rb_valid; a new start then loads 48 bits from count 0.
REQ-039 pReset asserted mid-LOAD -> all outputs 0 asynchronously; start after release is accepted.
